decomp_output: RTL and testbench

//  LZRW1 decompressor back end; mirror of the compressor input stage. Takes decoded tokens (literal byte or

---
 rtl/decomp_output.sv | 173 +++++++++++++++++
 tb/tb_decomp_output.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/decomp_output.sv
// ---------------------------------------------------------------------------
// decomp_output -- LZRW1 decompressor back end.
//
// Rebuilds the original byte stream from decoded tokens (literal byte or copy
// item {offset,length}), emitting one byte per cycle.  Every emitted byte is
// also written into a circular history so later copy items can reference it.
// Copy offsets are absolute history indices, exactly as the compressor emits.
//
// Ports
//   clock, reset         rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    token handshake (accept when both high)
//   in_is_copy           1 = copy item, 0 = literal
//   in_literal           literal byte
//   in_offset            absolute history index of the copy source
//   in_length            copy length, legal 3..15
//   in_last              token is the last of the stream
//   out_valid/out_ready  byte handshake (transfer when both high)
//   out_byte             reconstructed byte
//   out_last             final byte of the stream (qualified by out_valid)
//   wr_ptr               history index of the next byte to be written
//   done                 stream complete, sticky until reset
//   error                illegal copy token seen, sticky until reset
// ---------------------------------------------------------------------------
module decomp_output #(
   parameter int HISTORY = 4096
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_is_copy,
   input  logic [7:0]                 in_literal,
   input  logic [$clog2(HISTORY)-1:0] in_offset,
   input  logic [3:0]                 in_length,
   input  logic                       in_last,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [7:0]                 out_byte,
   output logic                       out_last,
   output logic [$clog2(HISTORY)-1:0] wr_ptr,
   output logic                       done,
   output logic                       error
);

   localparam int AW = $clog2(HISTORY);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW-1:0] PTR_MAX = {AW{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LIT  = 2'd1,
      COPY = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t          state_r, state_next_s;
   logic [7:0]      history_r [HISTORY];
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [3:0]      remain_r;
   logic [7:0]      lit_r;
   logic            last_r;
   logic            wrapped_r;
   logic            error_r;

   logic            accept_s;
   logic            copy_legal_s;
   logic            out_valid_s;
   logic            transfer_s;
   logic            final_byte_s;
   logic [7:0]      out_byte_s;

   // Handshake qualifiers and copy legality; a copy may only reference bytes already written.
   always_comb begin
      accept_s     = in_valid && (state_r == IDLE) && !reset;
      copy_legal_s = (in_length >= 4'd3) && (wrapped_r || (in_offset < wr_ptr_r));
      out_valid_s  = (state_r == LIT) || (state_r == COPY);
      transfer_s   = out_valid_s && out_ready;
      final_byte_s = (state_r == LIT) || (remain_r == 4'd1);
   end

   // Byte being presented: literal register or a combinational history read.
   always_comb begin
      out_byte_s = 8'h00;
      case (state_r)
         LIT:     out_byte_s = lit_r;
         COPY:    out_byte_s = history_r[rd_ptr_r];
         default: out_byte_s = 8'h00;
      endcase
   end

   // Next-state decision.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (!in_is_copy) begin
                  state_next_s = LIT;
               end else if (copy_legal_s) begin
                  state_next_s = COPY;
               end else begin
                  state_next_s = IDLE;
               end
            end else begin
               state_next_s = IDLE;
            end
         end
         LIT, COPY: begin
            if (transfer_s && final_byte_s) begin
               state_next_s = last_r ? DONE : IDLE;
            end else begin
               state_next_s = state_r;
            end
         end
         DONE:    state_next_s = DONE;
         default: state_next_s = IDLE;
      endcase
   end

   // State register, token capture, history writes and pointers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r   <= IDLE;
         wr_ptr_r  <= '0;
         rd_ptr_r  <= '0;
         remain_r  <= 4'd0;
         lit_r     <= 8'h00;
         last_r    <= 1'b0;
         wrapped_r <= 1'b0;
         error_r   <= 1'b0;
         for (int i = 0; i < HISTORY; i++) begin
            history_r[i] <= 8'h00;
         end
      end else begin
         state_r <= state_next_s;
         if (accept_s) begin
            if (!in_is_copy) begin
               lit_r  <= in_literal;
               last_r <= in_last;
            end else if (copy_legal_s) begin
               rd_ptr_r <= in_offset;
               remain_r <= in_length;
               last_r   <= in_last;
            end else begin
               // Illegal copy is dropped entirely, including its in_last flag.
               error_r <= 1'b1;
            end
         end
         if (transfer_s) begin
            // The write lands before the next read, so overlapping copies replicate correctly.
            history_r[wr_ptr_r] <= out_byte_s;
            wr_ptr_r            <= wr_ptr_r + PTR_ONE;
            if (wr_ptr_r == PTR_MAX) begin
               wrapped_r <= 1'b1;
            end
            if (state_r == COPY) begin
               rd_ptr_r <= rd_ptr_r + PTR_ONE;
               remain_r <= remain_r - 4'd1;
            end
         end
      end
   end

   assign in_ready  = (state_r == IDLE) && !reset;
   assign out_valid = out_valid_s;
   assign out_byte  = out_byte_s;
   assign out_last  = out_valid_s && last_r && final_byte_s;
   assign wr_ptr    = wr_ptr_r;
   assign done      = (state_r == DONE);
   assign error     = error_r;

endmodule

// File: tb/tb_decomp_output.sv
module tb_decomp_output;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        in_is_copy;
   logic [7:0]  in_literal;
   logic [11:0] in_offset;
   logic [3:0]  in_length;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_byte;
   logic        out_last;
   logic [11:0] wr_ptr;
   logic        done;
   logic        error;

   int n_compared   = 0;
   int n_mismatched = 0;
   int cyc          = 0;

   logic [8:0] got_q [$];   // {out_last, out_byte}
   int         got_cyc_q [$];

   decomp_output #(.HISTORY(4096)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_is_copy(in_is_copy),
      .in_literal(in_literal), .in_offset(in_offset), .in_length(in_length),
      .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
      .out_byte(out_byte), .out_last(out_last), .wr_ptr(wr_ptr),
      .done(done), .error(error)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Byte collector: a transfer happens at the posedge following this sample.
   always @(negedge clock) begin
      if (out_valid && out_ready && !reset) begin
         got_q.push_back({out_last, out_byte});
         got_cyc_q.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge clock); #1;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b0;
      got_q.delete(); got_cyc_q.delete();
   endtask

   task automatic send(input logic c, input logic [7:0] l, input logic [11:0] o,
                       input logic [3:0] n, input logic last);
      int t = 0;
      @(negedge clock);
      while (!in_ready && t < 200) begin
         @(negedge clock); t++;
      end
      if (!in_ready) check("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b1; in_is_copy = c; in_literal = l; in_offset = o;
      in_length = n; in_last = last;
      @(posedge clock); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic wait_bytes(input int n);
      int t = 0;
      while (got_q.size() < n && t < 500) begin
         @(negedge clock); t++;
      end
      if (got_q.size() < n) check("drain_timeout", got_q.size(), n);
      @(negedge clock);
   endtask

   task automatic check_bytes(input string tag, input logic [7:0] exp [], input int start);
      for (int i = 0; i < exp.size(); i++) begin
         if (start + i < got_q.size())
            check($sformatf("%s_b%0d", tag, i), {24'd0, got_q[start + i][7:0]}, {24'd0, exp[i]});
         else
            check($sformatf("%s_b%0d_missing", tag, i), 32'd0, 32'd1);
      end
   endtask

   initial begin
      logic [7:0] e [];
      logic [7:0] held;
      logic       stalled;
      int         k;
      int         t;
      reset = 1'b1; in_valid = 1'b0; in_is_copy = 1'b0; in_literal = 8'h00;
      in_offset = 12'd0; in_length = 4'd0; in_last = 1'b0; out_ready = 1'b1;
      do_reset();

      // Reset state
      @(negedge clock);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_wr_ptr", {20'd0, wr_ptr}, 32'd0);
      check("rst_done_err", {30'd0, done, error}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // 1: three literals, first output the cycle after accept, 2 cycles per literal
      send(1'b0, 8'h41, 12'd0, 4'd0, 1'b0);
      @(negedge clock);
      check("t1_latency_valid", {31'd0, out_valid}, 32'd1);
      check("t1_latency_byte", {24'd0, out_byte}, 32'h41);
      check("t1_busy_in_ready", {31'd0, in_ready}, 32'd0);
      send(1'b0, 8'h42, 12'd0, 4'd0, 1'b0);
      send(1'b0, 8'h43, 12'd0, 4'd0, 1'b0);
      wait_bytes(3);
      e = '{8'h41, 8'h42, 8'h43};
      check_bytes("t1", e, 0);
      check("t1_spacing_a", got_cyc_q[1] - got_cyc_q[0], 32'd2);
      check("t1_spacing_b", got_cyc_q[2] - got_cyc_q[1], 32'd2);
      check("t1_wr_ptr", {20'd0, wr_ptr}, 32'd3);

      // 2: copy off=0 len=3 replays the literals
      send(1'b1, 8'h00, 12'd0, 4'd3, 1'b0);
      wait_bytes(6);
      e = '{8'h41, 8'h42, 8'h43};
      check_bytes("t2", e, 3);
      check("t2_wr_ptr", {20'd0, wr_ptr}, 32'd6);
      check("t2_hist3", {24'd0, dut.history_r[3]}, 32'h41);
      check("t2_hist5", {24'd0, dut.history_r[5]}, 32'h43);

      // 3: overlapping copy replicates one byte
      do_reset();
      send(1'b0, 8'h78, 12'd0, 4'd0, 1'b0);
      send(1'b1, 8'h00, 12'd0, 4'd5, 1'b0);
      wait_bytes(6);
      e = '{8'h78, 8'h78, 8'h78, 8'h78, 8'h78, 8'h78};
      check_bytes("t3", e, 0);
      check("t3_wr_ptr", {20'd0, wr_ptr}, 32'd6);

      // 4: copy len=8 under out_ready pattern 1,0,0,...
      do_reset();
      for (int i = 1; i <= 8; i++) send(1'b0, 8'(i * 17), 12'd0, 4'd0, 1'b0);
      wait_bytes(8);
      got_q.delete(); got_cyc_q.delete();
      send(1'b1, 8'h00, 12'd0, 4'd8, 1'b0);
      k = 0; stalled = 1'b0; held = 8'h00; t = 0;
      while (got_q.size() < 8 && t < 100) begin
         out_ready = (k % 3 == 0);
         k++; t++;
         @(negedge clock);
         if (stalled && out_valid)
            check($sformatf("t4_stable_%0d", k), {24'd0, out_byte}, {24'd0, held});
         stalled = out_valid && !out_ready;
         held    = out_byte;
         @(posedge clock); #1;
      end
      out_ready = 1'b1;
      wait_bytes(8);
      e = '{8'd17, 8'd34, 8'd51, 8'd68, 8'd85, 8'd102, 8'd119, 8'd136};
      check_bytes("t4", e, 0);
      check("t4_count", got_q.size(), 32'd8);

      // 5: illegal copies, then a copy that is legal only because history wrapped
      do_reset();
      for (int i = 0; i < 3; i++) send(1'b0, 8'(i + 1), 12'd0, 4'd0, 1'b0);
      wait_bytes(3);
      send(1'b1, 8'h00, 12'd10, 4'd4, 1'b1);
      @(negedge clock);
      check("t5_off_valid", {31'd0, out_valid}, 32'd0);
      check("t5_off_error", {31'd0, error}, 32'd1);
      check("t5_off_last_ignored", {31'd0, done}, 32'd0);
      do_reset();
      for (int i = 0; i < 3; i++) send(1'b0, 8'(i + 1), 12'd0, 4'd0, 1'b0);
      wait_bytes(3);
      send(1'b1, 8'h00, 12'd0, 4'd2, 1'b0);
      @(negedge clock);
      check("t5_len_valid", {31'd0, out_valid}, 32'd0);
      check("t5_len_error", {31'd0, error}, 32'd1);
      check("t5_len_wr_ptr", {20'd0, wr_ptr}, 32'd3);
      do_reset();
      for (int i = 0; i < 4096; i++) send(1'b0, 8'(i + 5), 12'd0, 4'd0, 1'b0);
      wait_bytes(4096);
      check("t5_wrap_wr_ptr", {20'd0, wr_ptr}, 32'd0);
      got_q.delete(); got_cyc_q.delete();
      send(1'b1, 8'h00, 12'd0, 4'd3, 1'b0);
      wait_bytes(3);
      e = '{8'h05, 8'h06, 8'h07};
      check_bytes("t5_wrap", e, 0);
      check("t5_wrap_error", {31'd0, error}, 32'd0);

      // 6a: last copy flags only its final byte, then DONE
      do_reset();
      for (int i = 1; i <= 4; i++) send(1'b0, 8'(i), 12'd0, 4'd0, 1'b0);
      wait_bytes(4);
      got_q.delete(); got_cyc_q.delete();
      send(1'b1, 8'h00, 12'd0, 4'd4, 1'b1);
      wait_bytes(4);
      for (int i = 0; i < 4; i++)
         check($sformatf("t6_last_%0d", i), {31'd0, got_q[i][8]}, (i == 3) ? 32'd1 : 32'd0);
      e = '{8'h01, 8'h02, 8'h03, 8'h04};
      check_bytes("t6", e, 0);
      check("t6_done", {31'd0, done}, 32'd1);
      check("t6_done_in_ready", {31'd0, in_ready}, 32'd0);
      check("t6_done_valid", {31'd0, out_valid}, 32'd0);

      // 6b: reset in the 2nd cycle of a copy aborts it
      do_reset();
      send(1'b0, 8'h99, 12'd0, 4'd0, 1'b0);
      wait_bytes(1);
      send(1'b1, 8'h00, 12'd0, 4'd4, 1'b0);
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
      check("t6_rst_wr_ptr", {20'd0, wr_ptr}, 32'd0);
      check("t6_rst_hist0", {24'd0, dut.history_r[0]}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
